// File: rtl/ysyx_24080018_imem_responder_if.sv
// Fetch bus between the IFU and the instruction-memory responder: request and
// response handshake channels plus the program-preload write port.
interface ysyx_24080018_imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // IFU / loader side
  modport master (
    output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  // memory side
  modport slave (
    input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/ysyx_24080018_imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, waits LATENCY
// cycles, then returns the addressed word (or an error) and holds it until the
// IFU takes it. A separate write port preloads the word array.
module ysyx_24080018_imem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] ERR_INST  = 32'h0000_0000
) (
  input logic                        clk,
  input logic                        rst,
  ysyx_24080018_imem_responder_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } rsp_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  rsp_t        r_rsp, w_rsp_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;

  logic [31:0] mem [DEPTH];

  logic        w_req_ready;
  logic        w_accept;
  logic [31:0] w_rd_off, w_wr_off;
  logic        w_rd_bad, w_wr_ok;
  logic [31:0] w_rd_word;

  // Offsets are 32-bit unsigned, so addresses below BASE_ADDR wrap to a huge
  // offset and fall out of range without a separate lower-bound check.
  assign w_rd_off  = r_addr - BASE_ADDR;
  assign w_rd_bad  = (r_addr[1:0] != 2'b00) || (w_rd_off >= MEM_BYTES);
  assign w_rd_word = mem[w_rd_off[AW+1:2]];

  assign w_wr_off  = bus.wr_addr - BASE_ADDR;
  assign w_wr_ok   = (bus.wr_addr[1:0] == 2'b00) && (w_wr_off < MEM_BYTES);

  // Ready is forced low while reset is held, not just after it registers.
  assign w_req_ready = (r_state == S_IDLE) && rst;
  assign w_accept    = bus.req_valid && w_req_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_inst  = r_rsp.inst;
  assign bus.rsp_err   = r_rsp.err;

  // Preload write; array is never reset. A read on the same edge sees old data.
  always_ff @(posedge clk) begin
    if (bus.wr_en && w_wr_ok) mem[w_wr_off[AW+1:2]] <= bus.wr_data;
  end

  // Next-state and datapath decode for the fetch FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_rsp_nxt       = r_rsp;
    w_rsp_valid_nxt = r_rsp_valid;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_nxt  = bus.req_addr;
          w_cnt_nxt   = 4'(LATENCY);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_rsp_nxt.err   = w_rd_bad;
          w_rsp_nxt.inst  = w_rd_bad ? ERR_INST : w_rd_word;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state and response registers; reset drops any in-flight fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= 32'd0;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_rsp       <= w_rsp_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_24080018_imem_responder.sv
// Bench for the instruction-memory responder: one instance at LATENCY=2 for
// directed and random fetches, one at LATENCY=0 for back-to-back throughput.
module tb_ysyx_24080018_imem_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT  = 2;

  logic clk, rst_a, rst_b;
  int   vectors = 0;
  int   miscompares = 0;

  ysyx_24080018_imem_responder_if ifa();
  ysyx_24080018_imem_responder_if ifb();

  ysyx_24080018_imem_responder #(.LATENCY(LAT)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  ysyx_24080018_imem_responder #(.LATENCY(0))   dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model of A's array: word index -> contents
  logic [31:0] model_a [int];
  int          written [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic valid_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 == 0) && (off < 32'd4096);
  endfunction

  task automatic expect_rsp(input logic [31:0] a, output logic err, output logic [31:0] inst);
    logic [31:0] off;
    off  = a - BASE;
    err  = !valid_addr(a);
    inst = err ? 32'h0 : (model_a.exists(int'(off / 4)) ? model_a[int'(off / 4)] : 32'hx);
  endtask

  task automatic write_a(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    ifa.wr_en = 1'b1; ifa.wr_addr = a; ifa.wr_data = d;
    step();
    ifa.wr_en = 1'b0;
    off = a - BASE;
    if (valid_addr(a)) begin
      if (!model_a.exists(int'(off / 4))) written.push_back(int'(off / 4));
      model_a[int'(off / 4)] = d;
    end
  endtask

  // Full fetch on A: checks exact latency, hold-stable behaviour over `hold`
  // stalled cycles, and return to IDLE one cycle after the handshake.
  // With same_wr set, wr_data is written to the fetched word on the read edge.
  task automatic fetch_a(input logic [31:0] a, input int hold,
                         input bit same_wr, input logic [31:0] wd);
    logic        e_err;
    logic [31:0] e_inst, off;
    chk("req_ready_idle", 32'(ifa.req_ready), 32'd1);
    ifa.req_valid = 1'b1; ifa.req_addr = a;
    step();                                   // accept edge T
    ifa.req_valid = 1'b0;
    for (int i = 0; i <= LAT; i++) begin      // after T .. T+LAT
      ifa.req_addr = $urandom;
      chk("wait_valid_low", 32'(ifa.rsp_valid), 32'd0);
      chk("wait_ready_low", 32'(ifa.req_ready), 32'd0);
      if (i == LAT) begin
        expect_rsp(a, e_err, e_inst);         // old data for a same-edge write
        if (same_wr) begin
          ifa.wr_en = 1'b1; ifa.wr_addr = a; ifa.wr_data = wd;
        end
      end
      step();
    end
    if (same_wr) begin
      ifa.wr_en = 1'b0;
      off = a - BASE;
      if (valid_addr(a)) model_a[int'(off / 4)] = wd;
    end
    chk("rsp_valid", 32'(ifa.rsp_valid), 32'd1);
    chk("rsp_inst", ifa.rsp_inst, e_inst);
    chk("rsp_err", 32'(ifa.rsp_err), 32'(e_err));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(ifa.rsp_valid), 32'd1);
      chk("hold_inst", ifa.rsp_inst, e_inst);
      chk("hold_ready_low", 32'(ifa.req_ready), 32'd0);
    end
    ifa.rsp_ready = 1'b1;
    step();
    ifa.rsp_ready = 1'b0;
    chk("post_hs_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("post_hs_ready", 32'(ifa.req_ready), 32'd1);
  endtask

  logic [31:0] b_words [3];
  int          acc, got;
  int          acc_cyc [3];
  logic [31:0] ra;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.rsp_ready = 1'b0;
    ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.rsp_ready = 1'b0;
    ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0;
    step();
    // reset state
    chk("rst_req_ready", 32'(ifa.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_rsp_inst", ifa.rsp_inst, 32'd0);
    chk("rst_rsp_err", 32'(ifa.rsp_err), 32'd0);
    chk("rst_b_req_ready", 32'(ifb.req_ready), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    step();
    chk("post_rst_ready", 32'(ifa.req_ready), 32'd1);

    // basic fetch, then a stalled response
    write_a(BASE + 32'h4, 32'h0010_0093);
    write_a(BASE, 32'h1111_2222);
    fetch_a(BASE + 32'h4, 0, 1'b0, '0);
    fetch_a(BASE + 32'h4, 5, 1'b0, '0);

    // invalid writes dropped, invalid fetches flagged
    write_a(BASE + 32'h2, 32'hBAD0_0001);
    write_a(BASE + 32'h1000, 32'hBAD0_0002);
    write_a(32'h7FFF_FFFC, 32'hBAD0_0003);
    fetch_a(BASE + 32'h2, 0, 1'b0, '0);
    fetch_a(BASE + 32'h1000, 0, 1'b0, '0);
    fetch_a(32'h7FFF_FFFC, 1, 1'b0, '0);
    fetch_a(BASE, 0, 1'b0, '0);
    fetch_a(BASE + 32'h4, 0, 1'b0, '0);
    write_a(BASE + 32'hFFC, 32'hCAFE_F00D);    // last word
    fetch_a(BASE + 32'hFFC, 0, 1'b0, '0);

    // same-edge write returns old data, repeat returns new
    fetch_a(BASE + 32'h4, 0, 1'b1, 32'hDEAD_BEEF);
    fetch_a(BASE + 32'h4, 0, 1'b0, '0);

    // reset during WAIT
    ifa.req_valid = 1'b1; ifa.req_addr = BASE + 32'h4;
    step();
    ifa.req_valid = 1'b0;
    rst_a = 1'b0;
    #1;
    chk("rst_wait_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_wait_ready", 32'(ifa.req_ready), 32'd0);
    step();
    rst_a = 1'b1;
    #1;
    chk("rst_wait_rel_ready", 32'(ifa.req_ready), 32'd1);
    chk("rst_wait_rel_valid", 32'(ifa.rsp_valid), 32'd0);
    step();
    // reset during RESP
    ifa.req_valid = 1'b1; ifa.req_addr = BASE + 32'h4;
    step();
    ifa.req_valid = 1'b0;
    for (int i = 0; i <= LAT; i++) step();
    chk("rst_resp_pre_valid", 32'(ifa.rsp_valid), 32'd1);
    rst_a = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_resp_inst", ifa.rsp_inst, 32'd0);
    chk("rst_resp_ready", 32'(ifa.req_ready), 32'd0);
    step();
    rst_a = 1'b1;
    step();
    chk("rst_resp_rel_ready", 32'(ifa.req_ready), 32'd1);
    fetch_a(BASE + 32'h4, 0, 1'b0, '0);        // array survives reset
    fetch_a(BASE, 0, 1'b0, '0);

    // random writes and fetches
    for (int i = 0; i < 20; i++)
      write_a(BASE + ($urandom_range(0, 1023) << 2), $urandom);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = BASE + (written[$urandom_range(0, written.size() - 1)] << 2)
                      + $urandom_range(1, 3);
        1:       ra = BASE + 32'h1000 + ($urandom_range(0, 4095) << 2);
        2:       ra = BASE - ($urandom_range(1, 4096) << 2);
        default: ra = BASE + (written[$urandom_range(0, written.size() - 1)] << 2);
      endcase
      if ($urandom_range(0, 3) == 0) write_a(BASE + ($urandom_range(0, 1023) << 2), $urandom);
      fetch_a(ra, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom);
    end

    // LATENCY=0 back-to-back on B
    for (int i = 0; i < 3; i++) begin
      b_words[i] = $urandom;
      ifb.wr_en = 1'b1; ifb.wr_addr = BASE + 32'(i * 4); ifb.wr_data = b_words[i];
      step();
    end
    ifb.wr_en = 1'b0;
    ifb.rsp_ready = 1'b1;
    acc = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      ifb.req_addr  = BASE + 32'(acc * 4);
      ifb.req_valid = (acc < 3);
      if (ifb.rsp_valid) begin
        chk("b2b_inst", ifb.rsp_inst, b_words[got]);
        chk("b2b_err", 32'(ifb.rsp_err), 32'd0);
        got++;
      end
      if (ifb.req_ready && acc < 3) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      step();
    end
    ifb.req_valid = 1'b0;
    chk("b2b_count", 32'(got), 32'd3);
    chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
